// File: rtl/spidergon_pkg.sv
// Shared spidergon node definitions: flit type codes, port indices, arbiter state.
// Latency: n/a (constants and helper function only).
// Backpressure: n/a.
package spidergon_pkg;

    // Width of the flit type field carried in the top bits of every flit
    localparam int HEAD_TAIL = 2;

    localparam logic [1:0] HEAD_FLIT = 2'b01;
    localparam logic [1:0] BODY_FLIT = 2'b10;
    localparam logic [1:0] TAIL_FLIT = 2'b00;
    localparam logic [1:0] HEADER    = 2'b11;

    // Output port indices of a spidergon node
    localparam int ANTI_CLOCKWISE = 0;
    localparam int CLOCKWISE      = 1;
    localparam int ACROSS         = 2;
    localparam int STOP           = 3;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // Index width that stays at least one bit for single-entry vectors
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spidergon_rr_picker.sv
// Rotate-priority picker: first eligible entry scanning upward from rr_ptr_i, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller gates eligibility.
module spidergon_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the N positions starting at the pointer; the first eligible one wins
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!valid_o && eligible_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spidergon_output_arbiter.sv
// Wormhole output-link allocator: round-robin on head flits, link locked until the tail passes.
// Latency: one cycle from req_valid&&req_ready to out_valid; req_ready is combinational.
// Backpressure: per-VC OFF (downstream_vc_full) stalls the owner; optional SPIDERGON_ARB_WATCHDOG_EN flags long stalls.
module spidergon_output_arbiter
    import spidergon_pkg::*;
#(
    parameter int NUM_OF_REQUESTERS       = 4,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
`ifdef SPIDERGON_ARB_WATCHDOG_EN
    parameter int WATCHDOG_CYCLES         = 64,
`endif
    localparam int FW    = FLIT_DATA_WIDTH + HEAD_TAIL,
    localparam int VC_W  = idx_width(NUM_OF_VIRTUAL_CHANNELS),
    localparam int PTR_W = idx_width(NUM_OF_REQUESTERS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_OF_REQUESTERS-1:0]      req_valid,
    input  logic [NUM_OF_REQUESTERS*FW-1:0]   req_flit,
    input  logic [NUM_OF_REQUESTERS*VC_W-1:0] req_vc,
    output logic [NUM_OF_REQUESTERS-1:0]      req_ready,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] downstream_vc_full,
    output logic                              out_valid,
    output logic [FW-1:0]                     out_flit,
    output logic [VC_W-1:0]                   out_vc,
    output logic [NUM_OF_REQUESTERS-1:0]      grant,
    output logic                              locked
`ifdef SPIDERGON_ARB_WATCHDOG_EN
    ,output logic                             stall_timeout
`endif
);

    localparam int N = NUM_OF_REQUESTERS;

    arb_state_e       state_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [VC_W-1:0]  owner_vc_q;
    logic [N-1:0]     grant_q;
    logic             locked_q;
    logic             out_valid_q;
    logic [FW-1:0]    out_flit_q;
    logic [VC_W-1:0]  out_vc_q;

    logic [FW-1:0]    flit_a [N];
    logic [1:0]       typ_a  [N];
    logic [VC_W-1:0]  vc_a   [N];
    logic [N-1:0]     eligible;
    logic [N-1:0]     pick_win;
    logic             pick_vld;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] sel_idx;
    logic [1:0]       sel_typ;
    logic             xfer;
    logic [FW-1:0]    out_flit_d;
    logic [VC_W-1:0]  out_vc_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Unpack the flat buses; only heads/headers on a non-full VC may open a packet
    always_comb begin
        for (int i = 0; i < N; i++) begin
            flit_a[i]   = req_flit[i*FW +: FW];
            typ_a[i]    = flit_a[i][FW-1 -: HEAD_TAIL];
            vc_a[i]     = req_vc[i*VC_W +: VC_W];
            eligible[i] = req_valid[i] && (typ_a[i] == HEAD_FLIT || typ_a[i] == HEADER)
                          && !downstream_vc_full[vc_a[i]];
        end
    end

    spidergon_rr_picker #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_picker (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .winner_o   (pick_win),
        .valid_o    (pick_vld)
    );

    // One-hot winner to index
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_win[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Select the transferring source: the picker winner when idle, the owner when locked
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        sel_idx   = (state_q == LOCKED) ? owner_q : win_idx;
        if (!reset) begin
            if (state_q == IDLE) begin
                if (pick_vld) begin
                    xfer      = 1'b1;
                    req_ready = pick_win;
                end
            end else if (req_valid[owner_q] && !downstream_vc_full[owner_vc_q]) begin
                xfer               = 1'b1;
                req_ready[owner_q] = 1'b1;
            end
        end
        sel_typ    = typ_a[sel_idx];
        out_flit_d = flit_a[sel_idx];
        out_vc_d   = (state_q == LOCKED) ? owner_vc_q : vc_a[sel_idx];
        // A stray head inside a locked packet continues the worm as a body flit
        if (state_q == LOCKED && sel_typ == HEAD_FLIT) begin
            out_flit_d[FW-1 -: HEAD_TAIL] = BODY_FLIT;
        end
    end

    // Arbiter FSM with registered output flit, grant and lock flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vc_q  <= '0;
            grant_q     <= '0;
            locked_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
        end else begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_flit_q <= out_flit_d;
                out_vc_q   <= out_vc_d;
            end
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (sel_typ == HEADER) begin
                            rr_ptr_q <= next_ptr(sel_idx);
                        end else begin
                            state_q    <= LOCKED;
                            owner_q    <= sel_idx;
                            owner_vc_q <= vc_a[sel_idx];
                            grant_q    <= pick_win;
                            locked_q   <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && sel_typ == TAIL_FLIT) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr(owner_q);
                        grant_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_vc    = out_vc_q;
    assign grant     = grant_q;
    assign locked    = locked_q;

`ifdef SPIDERGON_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;
    logic            stall_q;

    // Count consecutive locked cycles with no owner transfer, saturating at the limit
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == LOCKED && !xfer) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(WATCHDOG_CYCLES)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_cnt_d == WD_W'(WATCHDOG_CYCLES)) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign stall_timeout = stall_q;
`endif

endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// Scoreboard bench for spidergon_output_arbiter: directed vectors push expected flits, a monitor pops them.
// Latency: expects each transfer on out_* one cycle after req_valid&&req_ready.
// Backpressure: drives downstream_vc_full directly; SPIDERGON_ARB_WATCHDOG_EN adds the stall timeout case.
module tb_spidergon_output_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [71:0] req_flit;
    logic [3:0]  req_vc;
    logic [3:0]  req_ready;
    logic [1:0]  downstream_vc_full;
    logic        out_valid;
    logic [17:0] out_flit;
    logic        out_vc;
    logic [3:0]  grant;
    logic        locked;
`ifdef SPIDERGON_ARB_WATCHDOG_EN
    logic        stall_timeout;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    spidergon_output_arbiter #(
        .NUM_OF_REQUESTERS       (4),
        .FLIT_DATA_WIDTH         (16),
        .NUM_OF_VIRTUAL_CHANNELS (2)
`ifdef SPIDERGON_ARB_WATCHDOG_EN
        ,.WATCHDOG_CYCLES        (8)
`endif
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_flit           (req_flit),
        .req_vc             (req_vc),
        .req_ready          (req_ready),
        .downstream_vc_full (downstream_vc_full),
        .out_valid          (out_valid),
        .out_flit           (out_flit),
        .out_vc             (out_vc),
        .grant              (grant),
        .locked             (locked)
`ifdef SPIDERGON_ARB_WATCHDOG_EN
        ,.stall_timeout     (stall_timeout)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] typ, input logic [15:0] dat, input logic vc);
        req_valid[r]         = 1'b1;
        req_flit[r*18 +: 18] = {typ, dat};
        req_vc[r]            = vc;
    endtask

    task automatic expect_out(input logic [1:0] typ, input logic [15:0] dat, input logic vc);
        exp_q.push_back({vc, typ, dat});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every presented output flit must match the oldest expected entry
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL out_unexpected: actual vc=%0h flit=%0h required none", out_vc, out_flit);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({out_vc, out_flit} !== e) begin
                    mismatched++;
                    $display("FAIL out_flit: actual vc=%0h flit=%0h required vc=%0h flit=%0h",
                             out_vc, out_flit, e[18], e[17:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int win [5];
        logic [1:0] pkt_typ [4];
        win = '{0, 1, 2, 3, 0};
        pkt_typ = '{2'b01, 2'b10, 2'b10, 2'b00};

        reset = 1'b1;
        req_valid = '0;
        req_flit = '0;
        req_vc = '0;
        downstream_vc_full = '0;

        // Reset: no ready even with a valid header, all outputs cleared
        @(negedge clk);
        set_req(0, 2'b11, 16'hAAAA, 1'b0);
        #1 check("rst_ready", req_ready, 4'b0000);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_vc", out_vc, 0);
        check("rst_grant", grant, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;
        req_valid = '0;

        // Contention: header-only flits from all four, rotation 0,1,2,3,0
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 4; r++) begin
                set_req(r, 2'b11, 16'(16'h1000 + c*16 + r), r[0]);
            end
            #1 check("contention_ready", req_ready, 32'(4'b0001 << win[c]));
            expect_out(2'b11, 16'(16'h1000 + c*16 + win[c]), win[c] % 2 == 1);
            tick();
        end
        req_valid = '0;
        check("hdr_grant_idle", grant, 0);
        check("hdr_locked_idle", locked, 0);

        // Single packet from requester 1 on VC1
        for (int k = 0; k < 4; k++) begin
            set_req(1, pkt_typ[k], 16'(16'h2000 + k), 1'b1);
            #1 check("pkt_ready", req_ready, 4'b0010);
            expect_out(pkt_typ[k], 16'(16'h2000 + k), 1'b1);
            tick();
            if (k < 3) begin
                check("pkt_grant", grant, 4'b0010);
                check("pkt_locked", locked, 1);
            end
        end
        req_valid = '0;
        check("pkt_grant_after_tail", grant, 0);
        check("pkt_locked_after_tail", locked, 0);

        // Pointer now 2: all four heads-only present, requester 2 wins
        for (int r = 0; r < 4; r++) set_req(r, 2'b11, 16'(16'h3000 + r), 1'b0);
        #1 check("rrptr_after_pkt", req_ready, 4'b0100);
        expect_out(2'b11, 16'h3002, 1'b0);
        tick();
        req_valid = '0;

        // Lock exclusivity: requester 0 owns, requester 2 waits with a head
        set_req(0, 2'b01, 16'h4000, 1'b0);
        #1 check("lock_head_ready", req_ready, 4'b0001);
        expect_out(2'b01, 16'h4000, 1'b0);
        tick();
        set_req(2, 2'b01, 16'h5000, 1'b1);
        set_req(0, 2'b10, 16'h4001, 1'b0);
        #1 check("lock_excl_ready1", req_ready, 4'b0001);
        expect_out(2'b10, 16'h4001, 1'b0);
        tick();
        set_req(0, 2'b01, 16'h4002, 1'b1);
        #1 check("lock_excl_ready2", req_ready, 4'b0001);
        expect_out(2'b10, 16'h4002, 1'b0);
        tick();
        set_req(0, 2'b00, 16'h4003, 1'b0);
        #1 check("lock_excl_ready3", req_ready, 4'b0001);
        expect_out(2'b00, 16'h4003, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        #1 check("lock_next_ready", req_ready, 4'b0100);
        expect_out(2'b01, 16'h5000, 1'b1);
        tick();
        check("lock_next_grant", grant, 4'b0100);
        set_req(2, 2'b00, 16'h5001, 1'b0);
        #1 check("lock_tail2_ready", req_ready, 4'b0100);
        expect_out(2'b00, 16'h5001, 1'b1);
        tick();
        req_valid = '0;

        // Backpressure: VC0 full for 5 cycles in the middle of requester 3's packet
        set_req(3, 2'b01, 16'h6000, 1'b0);
        #1 check("bp_head_ready", req_ready, 4'b1000);
        expect_out(2'b01, 16'h6000, 1'b0);
        tick();
        set_req(3, 2'b10, 16'h6001, 1'b0);
        #1 check("bp_body1_ready", req_ready, 4'b1000);
        expect_out(2'b10, 16'h6001, 1'b0);
        tick();
        downstream_vc_full = 2'b01;
        set_req(3, 2'b10, 16'h6002, 1'b0);
        set_req(1, 2'b01, 16'h7000, 1'b1);
        for (int s = 0; s < 5; s++) begin
            #1 check("bp_stall_ready", req_ready, 4'b0000);
            if (s > 0) check("bp_stall_out_valid", out_valid, 0);
            check("bp_stall_locked", locked, 1);
            tick();
        end
        downstream_vc_full = 2'b00;
        #1 check("bp_resume_ready", req_ready, 4'b1000);
        expect_out(2'b10, 16'h6002, 1'b0);
        tick();
        set_req(3, 2'b00, 16'h6003, 1'b0);
        #1 check("bp_tail_ready", req_ready, 4'b1000);
        expect_out(2'b00, 16'h6003, 1'b0);
        tick();
        req_valid[3] = 1'b0;
        #1 check("bp_waiter_ready", req_ready, 4'b0010);
        expect_out(2'b01, 16'h7000, 1'b1);
        tick();
        set_req(1, 2'b00, 16'h7001, 1'b1);
        #1 check("bp_waiter_tail_ready", req_ready, 4'b0010);
        expect_out(2'b00, 16'h7001, 1'b1);
        tick();
        req_valid = '0;

        // Idle eligibility: requester 3 is first in rotation but its VC is full
        downstream_vc_full = 2'b10;
        set_req(3, 2'b01, 16'h7200, 1'b1);
        set_req(0, 2'b01, 16'h7300, 1'b0);
        #1 check("vcfull_skip_ready", req_ready, 4'b0001);
        expect_out(2'b01, 16'h7300, 1'b0);
        tick();
        req_valid[3] = 1'b0;
        downstream_vc_full = 2'b00;
        set_req(0, 2'b00, 16'h7301, 1'b0);
        #1 check("vcfull_tail_ready", req_ready, 4'b0001);
        expect_out(2'b00, 16'h7301, 1'b0);
        tick();
        req_valid = '0;

        // Protocol guard: body and tail flits in idle are never granted
        set_req(1, 2'b10, 16'h8000, 1'b0);
        set_req(2, 2'b00, 16'h8001, 1'b1);
        for (int s = 0; s < 2; s++) begin
            #1 check("guard_ready", req_ready, 4'b0000);
            tick();
            check("guard_locked", locked, 0);
        end
        req_valid = '0;

        // Reset in the middle of a packet abandons the lock
        set_req(0, 2'b01, 16'h9000, 1'b0);
        #1 check("rstmid_head_ready", req_ready, 4'b0001);
        expect_out(2'b01, 16'h9000, 1'b0);
        tick();
        set_req(0, 2'b10, 16'h9001, 1'b0);
        #1 check("rstmid_body_ready", req_ready, 4'b0001);
        expect_out(2'b10, 16'h9001, 1'b0);
        tick();
        set_req(0, 2'b10, 16'h9002, 1'b0);
        reset = 1'b1;
        #1 check("rstmid_ready", req_ready, 4'b0000);
        tick();
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_flit", out_flit, 0);
        check("rstmid_grant", grant, 0);
        check("rstmid_locked", locked, 0);
        reset = 1'b0;
        #1 check("rstmid_body_idle_ready", req_ready, 4'b0000);
        tick();
        req_valid = '0;
        for (int r = 0; r < 4; r++) set_req(r, 2'b11, 16'(16'hA000 + r), 1'b0);
        #1 check("rstmid_rrptr", req_ready, 4'b0001);
        expect_out(2'b11, 16'hA000, 1'b0);
        tick();
        req_valid = '0;
        tick();

`ifdef SPIDERGON_ARB_WATCHDOG_EN
        // Watchdog: 8 locked cycles without progress set the sticky timeout
        set_req(0, 2'b01, 16'hB000, 1'b0);
        #1 check("wd_head_ready", req_ready, 4'b0001);
        expect_out(2'b01, 16'hB000, 1'b0);
        tick();
        downstream_vc_full = 2'b01;
        set_req(0, 2'b10, 16'hB001, 1'b0);
        for (int s = 0; s < 7; s++) tick();
        check("wd_before_limit", stall_timeout, 0);
        tick();
        check("wd_at_limit", stall_timeout, 1);
        downstream_vc_full = 2'b00;
        expect_out(2'b10, 16'hB001, 1'b0);
        tick();
        set_req(0, 2'b00, 16'hB002, 1'b0);
        expect_out(2'b00, 16'hB002, 1'b0);
        tick();
        req_valid = '0;
        tick();
        check("wd_sticky", stall_timeout, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wd_reset_clear", stall_timeout, 0);
`endif

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spidergon_output_arbiter.md
Name: spidergon_output_arbiter

Overview:
- Wormhole switch allocator for one output link of a spidergon node (across, clockwise, anti-clockwise or local eject).
- Shares that link between NUM_OF_REQUESTERS input sources (3 input ports + local CPU injection) using round-robin arbitration on head flits.
- Locks the link to the winning packet until its tail flit passes.
- Honours per-VC ON/OFF backpressure from the downstream node; one instance per output port.

Parameters:
- NUM_OF_REQUESTERS, 4, number of input sources competing for the link.
- FLIT_DATA_WIDTH, 16, payload width; flit total width = FLIT_DATA_WIDTH+2.
- NUM_OF_VIRTUAL_CHANNELS, 2, downstream VCs; VC_W = max(1, clog2(NUM_OF_VIRTUAL_CHANNELS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_OF_REQUESTERS  requester i presents a flit.
- req_flit  in  NUM_OF_REQUESTERS*(FLIT_DATA_WIDTH+2)  flit per requester; bits [top:top-1] are the type: 01 head, 10 body, 00 tail, 11 header-only.
- req_vc  in  NUM_OF_REQUESTERS*VC_W  downstream VC requested by requester i.
- req_ready  out  NUM_OF_REQUESTERS  flit of requester i consumed this cycle (combinational).
- downstream_vc_full  in  NUM_OF_VIRTUAL_CHANNELS  OFF signal per downstream VC.
- out_valid  out  1  registered output flit valid.
- out_flit  out  FLIT_DATA_WIDTH+2  registered output flit.
- out_vc  out  VC_W  VC tag of out_flit.
- grant  out  NUM_OF_REQUESTERS  one-hot current owner; zero when IDLE.
- locked  out  1  link held by a multi-flit packet.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr = 0.
  - out_valid = 0, out_flit = 0, out_vc = 0.
  - grant = 0, locked = 0.
  - req_ready = 0 while reset is high.
- A transfer occurs for requester i when req_valid[i] && req_ready[i]. The flit appears on out_* exactly 1 cycle later.
- When no transfer occurs, out_valid = 0 next cycle and out_flit/out_vc hold their previous values.
- State IDLE:
  - Eligible requester: req_valid=1, type is 01 or 11, and downstream_vc_full[req_vc]=0.
  - Winner: the first eligible requester scanning from rr_ptr upward, with wrap-around modulo NUM_OF_REQUESTERS.
  - req_ready is asserted for the winner only, in the same cycle.
  - Winner type 11: state stays IDLE; rr_ptr <= winner+1 (wrap).
  - Winner type 01: state goes to LOCKED; owner <= winner; owner_vc <= req_vc[winner]; grant/locked update next cycle.
  - Body or tail flits presented in IDLE are never granted; req_ready stays 0.
- State LOCKED:
  - req_ready[owner] = req_valid[owner] && !downstream_vc_full[owner_vc]; all other req_ready = 0.
  - The owner's req_vc is ignored; owner_vc is used for out_vc.
  - Owner type 10 transferred: stay LOCKED.
  - Owner type 00 transferred: go to IDLE; rr_ptr <= owner+1 (wrap); grant and locked clear next cycle.
  - A head flit from the owner while LOCKED is forwarded as a body flit and the lock is retained (wormhole continuity).
- Backpressure: while downstream_vc_full[owner_vc]=1 the packet stalls with no flit loss and the lock is held indefinitely.
- Fairness: after a packet completes, its requester gets lowest priority. With all requesters active, each gets the link within NUM_OF_REQUESTERS packets.
- Reset mid-packet (synchronous): the lock is abandoned and all state returns to reset values. The partial packet is not completed; upstream is reset by the same signal.

Optional Feature:
- Macro: SPIDERGON_ARB_WATCHDOG_EN.
- With the macro:
  - Adds output stall_timeout (1 bit) and parameter WATCHDOG_CYCLES (default 64).
  - A counter increments on each LOCKED cycle without a transfer and clears on any owner transfer or on leaving LOCKED.
  - stall_timeout is set (sticky) when the counter reaches WATCHDOG_CYCLES; it clears only on reset.
  - Arbitration behaviour is unchanged.
- Without the macro: no port, no counter, no parameter.

Decomposition:
- Shared package spidergon_pkg:
  - Flit type constants HEAD_FLIT=01, BODY_FLIT=10, TAIL_FLIT=00, HEADER=11.
  - HEAD_TAIL=2.
  - Port indices ANTI_CLOCKWISE=0, CLOCKWISE=1, ACROSS=2, STOP=3.
  - Arbiter state enum {IDLE, LOCKED}.
- One natural sub-module: spidergon_rr_picker, a combinational rotate-priority one-hot picker (inputs eligible vector and rr_ptr; output one-hot winner and valid). It is reusable for the node's VC allocator.

Test Plan:
- Single packet: requester 1 sends 01,10,10,00 on VC1, downstream not full → out_valid on 4 consecutive cycles, each 1 cycle after its input; out_vc=1; grant=0010 during the packet; IDLE after the tail; rr_ptr=2.
- Contention: all 4 requesters present type-11 flits continuously with rr_ptr=0 → grants in order 0,1,2,3,0; one flit per cycle.
- Lock exclusivity: requester 0 mid-packet while requester 2 presents a head → req_ready[2]=0 until requester 0's tail transfers; requester 2 granted in the following cycle.
- Backpressure: downstream_vc_full[0]=1 for 5 cycles during a VC0 packet body → req_ready[owner]=0 and out_valid=0 for 5 cycles; packet resumes with no flit lost or duplicated.
- Protocol guard and reset: a body flit in IDLE is never granted; reset asserted mid-packet → next cycle out_valid=0, grant=0, locked=0.
- With SPIDERGON_ARB_WATCHDOG_EN and WATCHDOG_CYCLES=8: hold the VC full for 8 LOCKED cycles → stall_timeout=1 and stays 1 until reset.
